// File: rtl/isr_sequencer_pkg.sv
// Shared types and constants for the JISR/RFE sequencer.
package isr_pkg;

  localparam int unsigned NCAUSE = 23;

  // Sequencer states: idle, one-cycle jump to the service routine, one-cycle return.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JUMP = 2'd1,
    RET  = 2'd2
  } state_t;

  // Named cause indices.
  localparam logic [4:0] CAUSE_RESET  = 5'd0;
  localparam logic [4:0] CAUSE_ILL    = 5'd16;
  localparam logic [4:0] CAUSE_MAL_LO = 5'd17;
  localparam logic [4:0] CAUSE_MAL_HI = 5'd18;
  localparam logic [4:0] CAUSE_PF_LO  = 5'd19;
  localparam logic [4:0] CAUSE_PF_HI  = 5'd20;

  // Bits 1..15, 21 and 22 can be masked by SR; the rest always get through.
  localparam logic [NCAUSE-1:0] MASKABLE = 23'h60FFFE;

  localparam logic [31:0] SISR_DEFAULT = 32'h0000_0000;

  // Repeat-type causes restart the faulting instruction (EPC <- pc_cur).
  function automatic logic is_repeat(input logic [4:0] il);
    return (il >= CAUSE_ILL) && (il <= CAUSE_PF_HI);
  endfunction

endpackage

// File: rtl/isr_sequencer_cause_prio.sv
// Cause masking and lowest-index priority encoding (purely combinational).
module cause_prio
  import isr_pkg::*;
(
  input  logic [NCAUSE-1:0] ca,
  input  logic [NCAUSE-1:0] sr,
  output logic [NCAUSE-1:0] mca,
  output logic              any,
  output logic [4:0]        il
);

  // Maskable bits are gated by SR; unmaskable bits pass straight through.
  always_comb begin
    mca = ca & (sr | ~MASKABLE);
    any = |mca;
  end

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    il = '0;
    for (int unsigned i = NCAUSE; i > 0; i--) begin
      if (mca[i-1]) il = 5'(i - 1);
    end
  end

endmodule

// File: rtl/isr_sequencer.sv
// JISR / RFE sequencer: owns SR, ESR, EPC, ECA, EDATA, latches external
// events and redirects the PC at instruction boundaries.
// Optional feature macro: ISR_COUNT_EN (builds a wrapping JUMP-entry counter).
module isr_sequencer
  import isr_pkg::*;
#(
  parameter int unsigned NCAUSE_P  = isr_pkg::NCAUSE,
  parameter logic [31:0] SISR_ADDR = isr_pkg::SISR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCAUSE_P-1:0] ca_int,
  input  logic [NCAUSE_P-1:0] ext_ev,
  input  logic                instr_done,
  input  logic [31:0]         pc_cur,
  input  logic [31:0]         pc_next,
  input  logic [31:0]         edata_in,
  input  logic                rfe,
  input  logic                sr_we,
  input  logic [31:0]         sr_wdata,
  output logic                jisr,
  output logic                redirect,
  output logic [31:0]         pc_redirect,
  output logic                busy,
  output logic [31:0]         sr,
  output logic [31:0]         esr,
  output logic [31:0]         epc,
  output logic [31:0]         edata,
  output logic [NCAUSE_P-1:0] eca,
  output logic [4:0]          il,
  output logic [31:0]         isr_count
);

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_sr, r_esr, r_epc, r_edata;
  logic [NCAUSE_P-1:0] r_eca, r_pend;
  logic [4:0]          r_il;

  logic [NCAUSE_P-1:0] w_ca, w_mca;
  logic                w_any;
  logic [4:0]          w_il;
  logic                w_idle, w_take, w_ret, w_sr_wr;
  logic [31:0]         w_sr_eff;

  assign w_ca = ca_int | r_pend;

  cause_prio u_prio (
    .ca  (w_ca),
    .sr  (r_sr[NCAUSE_P-1:0]),
    .mca (w_mca),
    .any (w_any),
    .il  (w_il)
  );

  // Boundary decode; everything except ext_ev is ignored outside IDLE.
  always_comb begin
    w_idle   = (r_state == IDLE);
    w_take   = w_idle & instr_done & w_any;
    w_ret    = w_idle & instr_done & rfe & ~w_any;
    w_sr_wr  = w_idle & sr_we;
    w_sr_eff = w_sr_wr ? sr_wdata : r_sr;
  end

  // Next-state logic: JUMP and RET each last exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_take)     w_state_nxt = JUMP;
        else if (w_ret) w_state_nxt = RET;
      end
      JUMP:    w_state_nxt = IDLE;
      RET:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sticky external events; a new event on the clearing edge survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~(w_take ? w_mca : '0)) | ext_ev;
  end

  // SR: a JUMP or RET overrides a same-cycle movi2s write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_sr <= '0;
    else if (w_take)  r_sr <= '0;
    else if (w_ret)   r_sr <= r_esr;
    else if (w_sr_wr) r_sr <= sr_wdata;
  end

  // Exception context capture on JUMP entry; an interrupted RFE re-executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_esr   <= '0;
      r_epc   <= '0;
      r_edata <= '0;
      r_eca   <= '0;
      r_il    <= '0;
    end else if (w_take) begin
      r_esr   <= w_sr_eff;
      r_epc   <= (is_repeat(w_il) || rfe) ? pc_cur : pc_next;
      r_edata <= edata_in;
      r_eca   <= w_mca;
      r_il    <= w_il;
    end
  end

`ifdef ISR_COUNT_EN
  logic [31:0] r_isr_count;

  // Counts JUMP entries; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_isr_count <= '0;
    else if (w_take) r_isr_count <= r_isr_count + 32'd1;
  end

  assign isr_count = r_isr_count;
`else
  assign isr_count = '0;
`endif

  // Outputs decoded from state and registers only.
  always_comb begin
    jisr        = (r_state == JUMP);
    redirect    = (r_state != IDLE);
    busy        = (r_state != IDLE);
    pc_redirect = '0;
    case (r_state)
      JUMP:    pc_redirect = SISR_ADDR;
      RET:     pc_redirect = r_epc;
      default: pc_redirect = '0;
    endcase
    sr    = r_sr;
    esr   = r_esr;
    epc   = r_epc;
    edata = r_edata;
    eca   = r_eca;
    il    = r_il;
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// Directed self-checking bench for isr_sequencer.
module tb_isr_sequencer;

  localparam int unsigned NC = 23;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] ca_int, ext_ev;
  logic          instr_done, rfe, sr_we;
  logic [31:0]   pc_cur, pc_next, edata_in, sr_wdata;
  logic          jisr, redirect, busy;
  logic [31:0]   pc_redirect, sr, esr, epc, edata, isr_count;
  logic [NC-1:0] eca;
  logic [4:0]    il;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  isr_sequencer #(.NCAUSE_P(NC), .SISR_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .ca_int(ca_int), .ext_ev(ext_ev),
    .instr_done(instr_done), .pc_cur(pc_cur), .pc_next(pc_next),
    .edata_in(edata_in), .rfe(rfe), .sr_we(sr_we), .sr_wdata(sr_wdata),
    .jisr(jisr), .redirect(redirect), .pc_redirect(pc_redirect), .busy(busy),
    .sr(sr), .esr(esr), .epc(epc), .edata(edata), .eca(eca), .il(il),
    .isr_count(isr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ca_int = '0; ext_ev = '0; instr_done = 0; rfe = 0; sr_we = 0;
    sr_wdata = '0; pc_cur = '0; pc_next = '0; edata_in = '0;
  endtask

  task automatic write_sr(input logic [31:0] v);
    sr_we = 1; sr_wdata = v; tick(); sr_we = 0; sr_wdata = '0;
  endtask

  task automatic pulse_ev(input int unsigned b);
    ext_ev = '0; ext_ev[b] = 1'b1; tick(); ext_ev = '0;
  endtask

  task automatic boundary(input logic [31:0] pc, input logic [31:0] pn);
    pc_cur = pc; pc_next = pn; instr_done = 1; tick(); instr_done = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_jisr", 32'(jisr), 0);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pcr", pc_redirect, 0);
    chk("rst_sr", sr, 0);
    chk("rst_epc", epc, 0);
    chk("rst_il", 32'(il), 0);
    chk("rst_pend", 32'(dut.r_pend), 0);
    chk("rst_cnt", isr_count, 0);
    reset = 0;
    tick();

    // Maskable external event 5 with SR enabling it.
    write_sr(32'h20);
    chk("sr_write", sr, 32'h20);
    pulse_ev(5);
    chk("pend5_set", 32'(dut.r_pend), 32'h20);
    chk("no_jump_wo_boundary", 32'(jisr), 0);
    edata_in = 32'hDEAD_BEEF;
    boundary(32'h100, 32'h104);
    edata_in = '0;
    chk("t1_jisr", 32'(jisr), 1);
    chk("t1_redirect", 32'(redirect), 1);
    chk("t1_pcr", pc_redirect, 32'h0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_epc", epc, 32'h104);
    chk("t1_eca", 32'(eca), 32'h20);
    chk("t1_il", 32'(il), 5);
    chk("t1_sr", sr, 0);
    chk("t1_esr", esr, 32'h20);
    chk("t1_edata", edata, 32'hDEAD_BEEF);
    chk("t1_pend_clr", 32'(dut.r_pend), 0);
    tick();
    chk("t1_back_idle", 32'(busy), 0);
    chk("t1_jisr_off", 32'(jisr), 0);

    // Masked event stays pending until SR enables it.
    pulse_ev(5);
    boundary(32'h104, 32'h108);
    chk("t2_masked_nojump", 32'(jisr), 0);
    chk("t2_pend_kept", 32'(dut.r_pend), 32'h20);
    write_sr(32'h20);
    chk("t2_nojump_on_srwe", 32'(jisr), 0);
    boundary(32'h108, 32'h10C);
    chk("t2_jisr", 32'(jisr), 1);
    chk("t2_epc", epc, 32'h10C);
    tick();

    // Unmaskable bit 16 vs enabled bit 3: bit 3 wins (continue type).
    write_sr(32'h8);
    pulse_ev(3);
    ca_int = 23'h10000;
    boundary(32'h200, 32'h204);
    ca_int = '0;
    chk("t3_il", 32'(il), 3);
    chk("t3_epc", epc, 32'h204);
    chk("t3_eca", 32'(eca), 32'h10008);
    tick();
    // Same with SR=0: bit 3 masked, bit 16 repeat-type wins.
    pulse_ev(3);
    ca_int = 23'h10000;
    boundary(32'h200, 32'h204);
    ca_int = '0;
    chk("t3b_il", 32'(il), 16);
    chk("t3b_epc", epc, 32'h200);
    chk("t3b_eca", 32'(eca), 32'h10000);
    chk("t3b_pend3_kept", 32'(dut.r_pend), 32'h8);
    tick();
    write_sr(32'h8);
    boundary(32'h210, 32'h214);
    chk("t3c_il", 32'(il), 3);
    tick();

    // Reset cause with same-cycle SR write: ESR takes the written value.
    ca_int = 23'h1; sr_we = 1; sr_wdata = 32'hFF;
    boundary(32'h2FC, 32'h300);
    ca_int = '0; sr_we = 0; sr_wdata = '0;
    chk("t4_il0", 32'(il), 0);
    chk("t4_esr_eff", esr, 32'hFF);
    chk("t4_sr_zero", sr, 0);
    chk("t4_epc", epc, 32'h300);
    tick();
    // Plain RFE.
    rfe = 1;
    boundary(32'h500, 32'h504);
    rfe = 0;
    chk("t4_ret_redirect", 32'(redirect), 1);
    chk("t4_ret_pcr", pc_redirect, 32'h300);
    chk("t4_ret_sr", sr, 32'hFF);
    chk("t4_ret_jisr", 32'(jisr), 0);
    chk("t4_ret_busy", 32'(busy), 1);
    tick();
    chk("t4_ret_done", 32'(redirect), 0);
    // RFE colliding with cause 17: the interrupt wins, EPC = pc_cur.
    rfe = 1; ca_int = 23'h20000;
    boundary(32'h400, 32'h404);
    rfe = 0; ca_int = '0;
    chk("t4b_jisr", 32'(jisr), 1);
    chk("t4b_epc", epc, 32'h400);
    chk("t4b_il", 32'(il), 17);
    chk("t4b_sr", sr, 0);
    tick();

    // New event on the edge that clears the same pending bit.
    write_sr(32'h4);
    pulse_ev(2);
    ext_ev = 23'h4;
    boundary(32'h600, 32'h604);
    ext_ev = '0;
    chk("t5_jisr", 32'(jisr), 1);
    chk("t5_eca", 32'(eca), 32'h4);
    chk("t5_pend2_kept", 32'(dut.r_pend), 32'h4);
    // Boundary, RFE and SR write during busy are all ignored.
    ca_int = 23'h1; rfe = 1; sr_we = 1; sr_wdata = 32'h55;
    instr_done = 1; pc_cur = 32'h700; pc_next = 32'h704;
    tick();
    instr_done = 0; ca_int = '0; rfe = 0; sr_we = 0; sr_wdata = '0;
    chk("t5_busy_ignored", 32'(jisr), 0);
    chk("t5_busy_idle", 32'(busy), 0);
    chk("t5_busy_sr", sr, 0);
    chk("t5_busy_epc", epc, 32'h604);

    // Reset asserted during JUMP clears everything at once.
    ca_int = 23'h1;
    boundary(32'h800, 32'h804);
    ca_int = '0;
    chk("t6_in_jump", 32'(jisr), 1);
    reset = 1;
    #1;
    chk("t6_rst_jisr", 32'(jisr), 0);
    chk("t6_rst_redirect", 32'(redirect), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_pcr", pc_redirect, 0);
    chk("t6_rst_epc", epc, 0);
    chk("t6_rst_pend", 32'(dut.r_pend), 0);
    tick();
    reset = 0;
    tick();

`ifdef ISR_COUNT_EN
    force dut.r_isr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_isr_count;
    ca_int = 23'h1;
    boundary(32'h900, 32'h904);
    ca_int = '0;
    chk("cnt_wrap", isr_count, 0);
    tick();
    ca_int = 23'h1;
    boundary(32'h910, 32'h914);
    ca_int = '0;
    chk("cnt_inc", isr_count, 1);
`else
    ca_int = 23'h1;
    boundary(32'h900, 32'h904);
    ca_int = '0;
    chk("cnt_tied", isr_count, 0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end

endmodule
